// File: rtl/led_pattern_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer.
// Contents:
//   - mode encodings (3 bits)
//   - LED count
//   - mode-advance helper
//   - initial-pattern helper
package led_pattern_sequencer_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned LED_N  = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 3'd0,
    MODE_BLINK  = 3'd1,
    MODE_CHASE  = 3'd2,
    MODE_BOUNCE = 3'd3,
    MODE_BINARY = 3'd4
  } mode_e;

  // Mode order driven by the step pulse. BINARY wraps back to OFF.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:    next_mode = MODE_BLINK;
      MODE_BLINK:  next_mode = MODE_CHASE;
      MODE_CHASE:  next_mode = MODE_BOUNCE;
      MODE_BOUNCE: next_mode = MODE_BINARY;
      default:     next_mode = MODE_OFF;
    endcase
  endfunction

  // Pattern loaded on entry to a mode. Bit 0 drives LED_1.
  function automatic logic [LED_N-1:0] init_pattern(input mode_e m);
    case (m)
      MODE_BLINK:  init_pattern = 4'b1111;
      MODE_CHASE:  init_pattern = 4'b0001;
      MODE_BOUNCE: init_pattern = 4'b0001;
      default:     init_pattern = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern tick generator.
// The counter runs 0..g_TICK_DIV-1 and wraps.
// o_Tick is high for the one cycle where the count sits at g_TICK_DIV-1.
// o_Tick is suppressed while disabled.
// Ports:
//   i_Clk    - system clock
//   i_Rst    - synchronous reset, active-high
//   i_Clear  - restart the count from 0 (takes priority over i_Enable)
//   i_Enable - 1 = count, 0 = hold
//   o_Tick   - one-cycle tick
module led_tick_gen #(
  parameter int unsigned g_TICK_DIV = 2500000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Tick
);

  localparam int unsigned W = $clog2(g_TICK_DIV);
  localparam logic [W-1:0] LAST = W'(g_TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_last;

  assign at_last = (cnt_q == LAST);
  assign o_Tick  = i_Enable & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (i_Clear) begin
      cnt_d = '0;
    end else if (i_Enable) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer.
// Steps the four board LEDs through OFF / BLINK / CHASE / BOUNCE / BINARY.
// A one-cycle i_Step pulse advances the mode.
// The pattern advances once per internally generated tick.
// Ports:
//   i_Clk            - system clock, 25 MHz
//   i_Rst            - synchronous reset, active-high
//   i_Step           - one-cycle pulse, advance mode
//   i_Enable         - 1 = run, 0 = freeze tick count and pattern
//   o_LED_1..o_LED_4 - pattern bits 0..3
//   o_Mode           - current mode encoding
//
// state       | meaning
// OFF    (0)  | all LEDs dark, no pattern updates
// BLINK  (1)  | all LEDs toggle every g_BLINK_TICKS ticks
// CHASE  (2)  | single lit LED rotating toward LED_4
// BOUNCE (3)  | single lit LED sweeping up and down
// BINARY (4)  | LEDs count up modulo 16
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int unsigned g_TICK_DIV    = 2500000,
  parameter int unsigned g_BLINK_TICKS = 5
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Step,
  input  logic              i_Enable,
  output logic              o_LED_1,
  output logic              o_LED_2,
  output logic              o_LED_3,
  output logic              o_LED_4,
  output logic [MODE_W-1:0] o_Mode
);

  // Keep at least one bit even when a single tick per half-period is chosen.
  localparam int unsigned BW = (g_BLINK_TICKS > 1) ? $clog2(g_BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(g_BLINK_TICKS - 1);

  mode_e            mode_q, mode_d;
  logic [LED_N-1:0] led_q, led_d;
  logic [BW-1:0]    blink_q, blink_d;
  logic             dir_up_q, dir_up_d;
  logic             tick;
  logic             tick_clr;

  led_tick_gen #(
    .g_TICK_DIV(g_TICK_DIV)
  ) u_tick_gen (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Clear  (tick_clr),
    .i_Enable (i_Enable),
    .o_Tick   (tick)
  );

  always_comb begin
    mode_d   = mode_q;
    led_d    = led_q;
    blink_d  = blink_q;
    dir_up_d = dir_up_q;
    tick_clr = 1'b0;

    if (mode_q > MODE_BINARY) begin
      // Unused encodings recover to a clean OFF state.
      mode_d   = MODE_OFF;
      led_d    = '0;
      blink_d  = '0;
      dir_up_d = 1'b1;
      tick_clr = 1'b1;
    end else if (i_Step) begin
      // A step on the tick cycle wins; the tick is dropped with the count clear.
      mode_d   = next_mode(mode_q);
      led_d    = init_pattern(next_mode(mode_q));
      blink_d  = '0;
      dir_up_d = 1'b1;
      tick_clr = 1'b1;
    end else if (tick) begin
      case (mode_q)
        MODE_BLINK: begin
          if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            led_d   = ~led_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
        MODE_CHASE: begin
          led_d = {led_q[LED_N-2:0], led_q[LED_N-1]};
        end
        MODE_BOUNCE: begin
          // Direction flips on the move that reaches an end, so each end lights for one tick.
          if (dir_up_q) begin
            led_d = {led_q[LED_N-2:0], 1'b0};
            if (led_q[LED_N-2]) dir_up_d = 1'b0;
          end else begin
            led_d = {1'b0, led_q[LED_N-1:1]};
            if (led_q[1]) dir_up_d = 1'b1;
          end
        end
        MODE_BINARY: begin
          led_d = led_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      mode_q   <= MODE_OFF;
      led_q    <= '0;
      blink_q  <= '0;
      dir_up_q <= 1'b1;
    end else begin
      mode_q   <= mode_d;
      led_q    <= led_d;
      blink_q  <= blink_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign o_LED_1 = led_q[0];
  assign o_LED_2 = led_q[1];
  assign o_LED_3 = led_q[2];
  assign o_LED_4 = led_q[3];
  assign o_Mode  = mode_q;

endmodule
